// File: rtl/alu_scheduler_pkg.sv
// Shared widths, flag positions, FSM encoding and command payload for the ALU scheduler.
package alu_scheduler_pkg;

  localparam int unsigned OPCODE_W = 5;
  localparam int unsigned DATA_W   = 8;
  localparam int unsigned FLAG_W   = 5;
  localparam int unsigned TIMER_W  = 8;

  localparam int unsigned FLG_CARRY  = 0;
  localparam int unsigned FLG_BORROW = 1;
  localparam int unsigned FLG_ZERO   = 2;
  localparam int unsigned FLG_NEG    = 3;
  localparam int unsigned FLG_OVF    = 4;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  typedef struct packed {
    logic [OPCODE_W-1:0] opcode;
    logic [DATA_W-1:0]   operand_a;
    logic [DATA_W-1:0]   operand_b;
    logic                carry_in;
    logic                borrow_in;
  } alu_cmd_t;

  // Place the individual ALU flags at their fixed bit positions
  function automatic logic [FLAG_W-1:0] pack_flags(
    input logic carry,
    input logic borrow,
    input logic zero,
    input logic neg,
    input logic ovf
  );
    logic [FLAG_W-1:0] f;
    f             = '0;
    f[FLG_CARRY]  = carry;
    f[FLG_BORROW] = borrow;
    f[FLG_ZERO]   = zero;
    f[FLG_NEG]    = neg;
    f[FLG_OVF]    = ovf;
    return f;
  endfunction

endpackage

// File: rtl/alu_scheduler_if.sv
// Request/response bus and ALU-side bus of the ALU scheduler; slave is the scheduler view.
interface alu_scheduler_if #(
  parameter int unsigned NUM_REQ = 4
);
  import alu_scheduler_pkg::*;

  logic [NUM_REQ-1:0]          req;
  logic [OPCODE_W*NUM_REQ-1:0] req_opcode;
  logic [DATA_W*NUM_REQ-1:0]   req_operand_A;
  logic [DATA_W*NUM_REQ-1:0]   req_operand_B;
  logic [NUM_REQ-1:0]          req_carry_in;
  logic [NUM_REQ-1:0]          req_borrow_in;

  logic [NUM_REQ-1:0]          done;
  logic [DATA_W-1:0]           resp_result;
  logic [FLAG_W-1:0]           resp_flags;
  logic                        resp_timeout;
  logic                        busy;

  logic [OPCODE_W-1:0]         alu_opcode;
  logic [DATA_W-1:0]           alu_operand_A;
  logic [DATA_W-1:0]           alu_operand_B;
  logic                        alu_carry_in;
  logic                        alu_borrow_in;
  logic                        alu_enable;
  logic                        alu_input_ready;

  logic [DATA_W-1:0]           alu_result;
  logic                        alu_carry_out;
  logic                        alu_borrow_out;
  logic                        alu_zero;
  logic                        alu_negative;
  logic                        alu_overflow;
  logic                        alu_result_ready;

  modport slave (
    input  req, req_opcode, req_operand_A, req_operand_B, req_carry_in, req_borrow_in,
    input  alu_result, alu_carry_out, alu_borrow_out, alu_zero, alu_negative,
    input  alu_overflow, alu_result_ready,
    output done, resp_result, resp_flags, resp_timeout, busy,
    output alu_opcode, alu_operand_A, alu_operand_B, alu_carry_in, alu_borrow_in,
    output alu_enable, alu_input_ready
  );

  modport master (
    output req, req_opcode, req_operand_A, req_operand_B, req_carry_in, req_borrow_in,
    output alu_result, alu_carry_out, alu_borrow_out, alu_zero, alu_negative,
    output alu_overflow, alu_result_ready,
    input  done, resp_result, resp_flags, resp_timeout, busy,
    input  alu_opcode, alu_operand_A, alu_operand_B, alu_carry_in, alu_borrow_in,
    input  alu_enable, alu_input_ready
  );

endinterface

// File: rtl/alu_scheduler_rr_arbiter.sv
// Combinational rotating-priority picker: search starts one past the last winner.
module rr_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] grant_c,
  output logic [IDX_W-1:0]   grant_idx_c,
  output logic               any_req_c
);

  function automatic logic [IDX_W-1:0] rot_idx(input logic [IDX_W-1:0] base, input int unsigned step);
    return IDX_W'((32'(base) + step) % NUM_REQ);
  endfunction

  always_comb begin
    grant_idx_c = '0;
    any_req_c   = 1'b0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      if (!any_req_c && req[rot_idx(ptr, k)]) begin
        any_req_c   = 1'b1;
        grant_idx_c = rot_idx(ptr, k);
      end
    end
    grant_c = any_req_c ? (NUM_REQ'(1) << grant_idx_c) : '0;
  end

endmodule

// File: rtl/alu_scheduler.sv
// Shares one ALU among NUM_REQ requesters: round-robin grant, single input_ready strobe,
// wait for result_ready or timeout, then a one-hot done pulse to the winner.
module alu_scheduler
  import alu_scheduler_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned TIMEOUT = 255
) (
  input logic            clk,
  input logic            rst,
  alu_scheduler_if.slave bus
);

  localparam int unsigned IDX_W = $clog2(NUM_REQ);

  state_e               state_q, state_d;
  logic [IDX_W-1:0]     ptr_q, ptr_d;
  logic [IDX_W-1:0]     win_q, win_d;
  logic [NUM_REQ-1:0]   grant_q, grant_d;
  logic [NUM_REQ-1:0]   done_q, done_d;
  logic [TIMER_W-1:0]   timer_q, timer_d;
  alu_cmd_t             cmd_q, cmd_d;
  logic                 input_ready_q, input_ready_d;
  logic [DATA_W-1:0]    result_q, result_d;
  logic [FLAG_W-1:0]    flags_q, flags_d;
  logic                 timeout_q, timeout_d;
  logic                 busy_q;
  logic                 enable_q;

  logic [NUM_REQ-1:0]   arb_grant_c;
  logic [IDX_W-1:0]     arb_idx_c;
  logic                 arb_any_c;
  alu_cmd_t             req_cmd_c;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_arb (
    .req         (bus.req),
    .ptr         (ptr_q),
    .grant_c     (arb_grant_c),
    .grant_idx_c (arb_idx_c),
    .any_req_c   (arb_any_c)
  );

  // Winner's slice of the packed request bus
  always_comb begin
    req_cmd_c.opcode    = bus.req_opcode[32'(arb_idx_c)*OPCODE_W +: OPCODE_W];
    req_cmd_c.operand_a = bus.req_operand_A[32'(arb_idx_c)*DATA_W +: DATA_W];
    req_cmd_c.operand_b = bus.req_operand_B[32'(arb_idx_c)*DATA_W +: DATA_W];
    req_cmd_c.carry_in  = bus.req_carry_in[arb_idx_c];
    req_cmd_c.borrow_in = bus.req_borrow_in[arb_idx_c];
  end

  // Next-state and next-register values
  always_comb begin
    state_d       = state_q;
    ptr_d         = ptr_q;
    win_d         = win_q;
    grant_d       = grant_q;
    cmd_d         = cmd_q;
    timer_d       = timer_q;
    input_ready_d = 1'b0;
    done_d        = '0;
    result_d      = result_q;
    flags_d       = flags_q;
    timeout_d     = timeout_q;

    case (state_q)
      S_IDLE: begin
        if (arb_any_c) begin
          win_d         = arb_idx_c;
          grant_d       = arb_grant_c;
          cmd_d         = req_cmd_c;
          input_ready_d = 1'b1;
          state_d       = S_ISSUE;
        end
      end
      S_ISSUE: begin
        timer_d = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (bus.alu_result_ready) begin
          result_d  = bus.alu_result;
          flags_d   = pack_flags(bus.alu_carry_out, bus.alu_borrow_out, bus.alu_zero,
                                 bus.alu_negative, bus.alu_overflow);
          timeout_d = 1'b0;
          done_d    = grant_q;
          state_d   = S_DONE;
        end else if (timer_q == TIMER_W'(TIMEOUT - 1)) begin
          result_d  = '0;
          flags_d   = '0;
          timeout_d = 1'b1;
          done_d    = grant_q;
          state_d   = S_DONE;
        end else begin
          timer_d = timer_q + TIMER_W'(1);
        end
      end
      S_DONE: begin
        ptr_d   = win_q;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  // Datapath and output registers; the pointer reset gives requester 0 first priority
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr_q         <= IDX_W'(NUM_REQ - 1);
      win_q         <= '0;
      grant_q       <= '0;
      done_q        <= '0;
      timer_q       <= '0;
      cmd_q         <= '0;
      input_ready_q <= 1'b0;
      result_q      <= '0;
      flags_q       <= '0;
      timeout_q     <= 1'b0;
      busy_q        <= 1'b0;
      enable_q      <= 1'b0;
    end else begin
      ptr_q         <= ptr_d;
      win_q         <= win_d;
      grant_q       <= grant_d;
      done_q        <= done_d;
      timer_q       <= timer_d;
      cmd_q         <= cmd_d;
      input_ready_q <= input_ready_d;
      result_q      <= result_d;
      flags_q       <= flags_d;
      timeout_q     <= timeout_d;
      busy_q        <= (state_d != S_IDLE);
      enable_q      <= 1'b1;
    end
  end

  assign bus.done            = done_q;
  assign bus.resp_result     = result_q;
  assign bus.resp_flags      = flags_q;
  assign bus.resp_timeout    = timeout_q;
  assign bus.busy            = busy_q;
  assign bus.alu_opcode      = cmd_q.opcode;
  assign bus.alu_operand_A   = cmd_q.operand_a;
  assign bus.alu_operand_B   = cmd_q.operand_b;
  assign bus.alu_carry_in    = cmd_q.carry_in;
  assign bus.alu_borrow_in   = cmd_q.borrow_in;
  assign bus.alu_enable      = enable_q;
  assign bus.alu_input_ready = input_ready_q;

endmodule

// File: tb/tb_alu_scheduler.sv
// Directed bench for alu_scheduler: vector table of single operations plus hand-written
// round-robin, request-drop and mid-operation reset sequences, against a small ALU model.
module tb_alu_scheduler;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  alu_scheduler_if #(.NUM_REQ(4)) bus ();

  alu_scheduler #(
    .NUM_REQ (4),
    .TIMEOUT (10)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;
  int ir_count = 0;
  int alu_delay = 1;
  bit alu_silent = 1'b0;
  logic [3:0] alu_cnt;

  // ALU stand-in: opcode 01 = add with carry, 02 = subtract with borrow
  function automatic logic [12:0] alu_model(input logic [4:0] op, input logic [7:0] a,
                                            input logic [7:0] b, input logic cin, input logic bin);
    logic [8:0] w;
    logic [7:0] r;
    logic c, bo, ov;
    w = '0; c = 1'b0; bo = 1'b0; ov = 1'b0;
    if (op == 5'h01) begin
      w  = {1'b0, a} + {1'b0, b} + {8'd0, cin};
      r  = w[7:0]; c = w[8];
      ov = (a[7] == b[7]) && (r[7] != a[7]);
    end else if (op == 5'h02) begin
      w  = {1'b0, a} - {1'b0, b} - {8'd0, bin};
      r  = w[7:0]; bo = w[8];
      ov = (a[7] != b[7]) && (r[7] != a[7]);
    end else begin
      r = 8'h00;
    end
    return {ov, r[7], (r == 8'h00), bo, c, r};
  endfunction

  always @(posedge clk or negedge rst) begin
    logic [12:0] m;
    if (!rst) begin
      alu_cnt <= '0;
      bus.alu_result_ready <= 1'b0;
      bus.alu_result <= '0;
      {bus.alu_overflow, bus.alu_negative, bus.alu_zero, bus.alu_borrow_out, bus.alu_carry_out} <= '0;
    end else if (bus.alu_input_ready) begin
      m = alu_model(bus.alu_opcode, bus.alu_operand_A, bus.alu_operand_B,
                    bus.alu_carry_in, bus.alu_borrow_in);
      bus.alu_result <= m[7:0];
      {bus.alu_overflow, bus.alu_negative, bus.alu_zero, bus.alu_borrow_out, bus.alu_carry_out} <= m[12:8];
      if (alu_silent) begin
        bus.alu_result_ready <= 1'b0;
        alu_cnt <= '0;
      end else if (alu_delay <= 1) begin
        bus.alu_result_ready <= 1'b1;
      end else begin
        bus.alu_result_ready <= 1'b0;
        alu_cnt <= 4'(alu_delay - 1);
      end
    end else if (alu_cnt != 0) begin
      alu_cnt <= alu_cnt - 4'd1;
      bus.alu_result_ready <= (alu_cnt == 4'd1);
    end else begin
      bus.alu_result_ready <= 1'b0;
    end
  end

  always @(negedge clk) if (rst && bus.alu_input_ready) ir_count <= ir_count + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ctrl"}, 32'({bus.done, bus.busy, bus.alu_input_ready, bus.alu_enable,
                              bus.resp_timeout, bus.resp_flags, bus.alu_carry_in, bus.alu_borrow_in}), 32'd0);
    check({tag, "_alu_cmd"}, 32'({bus.alu_opcode, bus.alu_operand_A, bus.alu_operand_B}), 32'd0);
    check({tag, "_result"}, 32'(bus.resp_result), 32'd0);
  endtask

  task automatic set_req(input int idx, input logic [4:0] op, input logic [7:0] a,
                         input logic [7:0] b, input logic cin, input logic bin);
    bus.req_opcode[idx*5 +: 5]    = op;
    bus.req_operand_A[idx*8 +: 8] = a;
    bus.req_operand_B[idx*8 +: 8] = b;
    bus.req_carry_in[idx]         = cin;
    bus.req_borrow_in[idx]        = bin;
  endtask

  // Advance until done is seen at a falling edge; cyc counts rising edges crossed
  task automatic wait_done(input int budget, output int cyc);
    bit seen;
    seen = 1'b0;
    cyc  = 0;
    while (!seen && cyc < budget) begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
      seen = (bus.done != '0);
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL wait_done: no done pulse within %0d cycles", budget);
    end
  endtask

  typedef struct {
    int         idx;
    logic [4:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic       bin;
    int         delay;
    bit         silent;
    logic [7:0] exp_res;
    logic [4:0] exp_flags;
    logic       exp_to;
    int         exp_lat;
  } vec_t;

  vec_t vecs[7];

  initial begin
    int cyc, gap, ir_before;

    vecs[0] = '{0, 5'h01, 8'h0F, 8'h01, 1'b0, 1'b0, 2, 1'b0, 8'h10, 5'b00000, 1'b0, 4};
    vecs[1] = '{1, 5'h01, 8'h80, 8'h80, 1'b0, 1'b0, 1, 1'b0, 8'h00, 5'b10101, 1'b0, 3};
    vecs[2] = '{3, 5'h01, 8'h7F, 8'h00, 1'b1, 1'b0, 3, 1'b0, 8'h80, 5'b11000, 1'b0, 5};
    vecs[3] = '{2, 5'h02, 8'h05, 8'h07, 1'b0, 1'b0, 1, 1'b0, 8'hFE, 5'b01010, 1'b0, 3};
    vecs[4] = '{1, 5'h02, 8'h10, 8'h0F, 1'b0, 1'b1, 2, 1'b0, 8'h00, 5'b00100, 1'b0, 4};
    vecs[5] = '{0, 5'h01, 8'hAA, 8'h55, 1'b0, 1'b0, 1, 1'b1, 8'h00, 5'b00000, 1'b1, 12};
    vecs[6] = '{2, 5'h01, 8'h01, 8'h01, 1'b0, 1'b0, 1, 1'b0, 8'h02, 5'b00000, 1'b0, 3};

    rst = 1'b0;
    bus.req = '0;
    bus.req_opcode = '0;
    bus.req_operand_A = '0;
    bus.req_operand_B = '0;
    bus.req_carry_in = '0;
    bus.req_borrow_in = '0;
    repeat (2) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b1;
    @(negedge clk);
    check("enable_after_reset", 32'(bus.alu_enable), 32'd1);
    check("busy_idle", 32'(bus.busy), 32'd0);

    // Continuous contention: expect grants 0,1,2,3,0 with 4 cycles between done pulses
    for (int i = 0; i < 4; i++) set_req(i, 5'h01, 8'(16 * i), 8'h01, 1'b0, 1'b0);
    alu_delay = 1;
    bus.req = 4'b1111;
    for (int n = 0; n < 5; n++) begin
      wait_done(30, cyc);
      gap = (n == 0) ? cyc : cyc + 1;
      check("rr_done", 32'(bus.done), 32'(4'b0001 << (n % 4)));
      check("rr_result", 32'(bus.resp_result), 32'(16 * (n % 4) + 1));
      check("rr_gap", 32'(gap), (n == 0) ? 32'd3 : 32'd4);
      if (n == 4) bus.req = '0;
      @(negedge clk);
      check("rr_done_width", 32'(bus.done), 32'd0);
      check("rr_busy_after_done", 32'(bus.busy), 32'd0);
    end
    repeat (2) @(negedge clk);

    // Single-request vectors including flag patterns and a timeout
    for (int v = 0; v < 7; v++) begin
      set_req(vecs[v].idx, vecs[v].op, vecs[v].a, vecs[v].b, vecs[v].cin, vecs[v].bin);
      alu_delay  = vecs[v].delay;
      alu_silent = vecs[v].silent;
      ir_before  = ir_count;
      bus.req    = 4'b0001 << vecs[v].idx;
      wait_done(30, cyc);
      check("vec_done", 32'(bus.done), 32'(4'b0001 << vecs[v].idx));
      check("vec_result", 32'(bus.resp_result), 32'(vecs[v].exp_res));
      check("vec_flags", 32'(bus.resp_flags), 32'(vecs[v].exp_flags));
      check("vec_timeout", 32'(bus.resp_timeout), 32'(vecs[v].exp_to));
      check("vec_latency", 32'(cyc), 32'(vecs[v].exp_lat));
      check("vec_input_ready_pulses", 32'(ir_count - ir_before), 32'd1);
      bus.req = '0;
      @(negedge clk);
      check("vec_done_width", 32'(bus.done), 32'd0);
      check("vec_resp_hold", 32'(bus.resp_result), 32'(vecs[v].exp_res));
      @(negedge clk);
    end
    alu_silent = 1'b0;

    // Request dropped and operands edited while waiting on the ALU
    set_req(2, 5'h01, 8'h33, 8'h11, 1'b0, 1'b0);
    alu_delay = 5;
    bus.req = 4'b0100;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    check("drop_in_wait_busy", 32'({bus.busy, bus.alu_input_ready}), 32'b10);
    bus.req = '0;
    set_req(2, 5'h02, 8'hFF, 8'hFF, 1'b1, 1'b1);
    wait_done(30, cyc);
    check("drop_done", 32'(bus.done), 32'b0100);
    check("drop_result", 32'(bus.resp_result), 32'h44);
    check("drop_latency", 32'(cyc), 32'd5);
    check("drop_operands", 32'({bus.alu_opcode, bus.alu_operand_A, bus.alu_operand_B}),
          32'({5'h01, 8'h33, 8'h11}));
    repeat (2) @(negedge clk);

    // Reset in WAIT: everything clears, no done, and requester 0 regains first priority
    set_req(0, 5'h01, 8'h12, 8'h34, 1'b0, 1'b0);
    set_req(3, 5'h01, 8'h50, 8'h50, 1'b0, 1'b0);
    alu_silent = 1'b1;
    bus.req = 4'b0001;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    check("pre_reset_busy", 32'(bus.busy), 32'd1);
    #2 rst = 1'b0;
    #1 check_all_zero("mid_reset");
    repeat (2) begin
      @(negedge clk);
      check("reset_no_done", 32'({bus.done, bus.busy}), 32'd0);
    end
    rst = 1'b1;
    alu_silent = 1'b0;
    alu_delay = 1;
    bus.req = 4'b1001;
    wait_done(30, cyc);
    check("post_reset_winner", 32'(bus.done), 32'b0001);
    check("post_reset_result", 32'(bus.resp_result), 32'h46);
    check("post_reset_latency", 32'(cyc), 32'd3);
    bus.req = '0;
    repeat (2) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/alu_scheduler.md
Name: alu_scheduler

Overview:
Round-robin scheduler that shares one 8-bit ALU instance among NUM_REQ requesters. It latches the winning requester's opcode, operands and carry/borrow inputs, then issues a single input_ready strobe to the ALU. It waits for result_ready, or times out, and returns the result and flags to the winner with a one-hot done pulse. It sits between the request sources (host/sequencers) and the alu block, replacing ad-hoc slow-clock sequencing with a handshake.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
TIMEOUT, 255, max cycles waited for alu_result_ready before aborting (1..255)

Ports:
clk  in  1  system clock; all logic on rising edge
rst  in  1  asynchronous, active-low reset
req  in  NUM_REQ  request per requester; held high until its done pulse
req_opcode  in  5*NUM_REQ  opcode per requester; slice i = [5i+4:5i]
req_operand_A  in  8*NUM_REQ  operand A per requester
req_operand_B  in  8*NUM_REQ  operand B per requester
req_carry_in  in  NUM_REQ  carry in per requester
req_borrow_in  in  NUM_REQ  borrow in per requester
done  out  NUM_REQ  one-hot, one-cycle completion pulse to the granted requester
resp_result  out  8  result, valid while done != 0
resp_flags  out  5  {overflow,negative,zero,borrow_out,carry_out}, valid with done
resp_timeout  out  1  high with done when the ALU did not answer
busy  out  1  high in every state except IDLE
alu_opcode  out  5  to alu.opcode
alu_operand_A  out  8  to alu.operand_A
alu_operand_B  out  8  to alu.operand_B
alu_carry_in  out  1  to alu.carry_in
alu_borrow_in  out  1  to alu.borrow_in
alu_enable  out  1  to alu.enable
alu_input_ready  out  1  to alu.input_ready, one-cycle strobe
alu_result  in  8  from alu.result_out
alu_carry_out, alu_borrow_out, alu_zero, alu_negative, alu_overflow  in  1 each  ALU flags
alu_result_ready  in  1  from alu.result_ready

Behaviour:
- Reset (rst=0, async): state=IDLE; pointer=NUM_REQ-1, so requester 0 has first priority. All outputs 0, except alu_enable=1 from the first clock after reset release. Any in-flight operation is dropped with no done pulse.
- IDLE: if req!=0, pick the winner by rotating priority starting at pointer+1 (wrap mod NUM_REQ). Latch the winner's opcode, operands, carry_in and borrow_in into the alu_* registers. Go to ISSUE. If req==0, stay in IDLE.
- ISSUE, 1 cycle: alu_input_ready=1, then go to WAIT with timer=0. The alu_* operand outputs stay stable from the latch until the next IDLE grant.
- WAIT: alu_input_ready=0.
  - If alu_result_ready=1: capture alu_result and the 5 flags, resp_timeout=0, go to DONE.
  - Else if timer==TIMEOUT-1: resp_result=0, resp_flags=0, resp_timeout=1, go to DONE.
  - Else timer+1 (8-bit, cannot wrap because of the bound).
- A result_ready already high when WAIT is entered is accepted on the first WAIT cycle.
- DONE, 1 cycle: done[winner]=1; resp_* hold the captured values. Then pointer=winner, go to IDLE.
- done, resp_result, resp_flags and resp_timeout are registered. done is 0 in all other states. resp_* keep their last values after DONE.
- Minimum latency from req to done: 4 cycles (IDLE grant, ISSUE, WAIT with ready, DONE). The next grant is possible in the cycle after DONE.
- Requests are sampled only in IDLE. A req that falls after the grant does not cancel: the operation completes and done still pulses. Changes to operand inputs after the grant are ignored.
- Simultaneous requests: exactly one grant per operation. Under continuous contention every requester is served within NUM_REQ operations.
- busy=1 in ISSUE, WAIT and DONE.

Decomposition:
- Shared include/package alu_defs: OPCODE_W=5, DATA_W=8, flag bit indices (FLG_CARRY=0, FLG_BORROW=1, FLG_ZERO=2, FLG_NEG=3, FLG_OVF=4), and the state encodings S_IDLE=0, S_ISSUE=1, S_WAIT=2, S_DONE=3.
- Sub-module rr_arbiter: combinational rotating-priority picker. Inputs are req and pointer; outputs are the one-hot grant and the binary index, with an any_req output. Instantiated once. The FSM, timer and registers stay in alu_scheduler.

Test Plan:
- Single request: req[0]=1 with opcode 5'h01, A=8'h0F, B=8'h01, ALU model answers 2 cycles after input_ready with 8'h10 -> exactly one input_ready pulse; done=4'b0001; resp_result=8'h10; resp_timeout=0.
- All four req high after reset, ALU answers immediately -> grants occur in order 0,1,2,3,0. Each done is one-hot and one cycle wide, with 4 cycles between consecutive done pulses.
- ALU never asserts result_ready, TIMEOUT=10 -> done 12 cycles after the grant cycle, with resp_timeout=1, resp_result=0, resp_flags=0; the scheduler then serves the next request.
- req[2] dropped in the WAIT state -> the operation still completes and done[2] pulses; the operands driven to the ALU are unchanged by later input edits.
- rst pulled low during WAIT -> all outputs go to 0 immediately with no done pulse. After release, requester 0 wins over a simultaneous requester 3.
- ALU flags model result 8'h00 with carry=1 and overflow=1 -> resp_flags=5'b10101.
